y86_dmem_responder: RTL

//  Target-side responder for the Y86-64 pipeline's memory-stage data port (the CPU is the initiator).

---
 rtl/y86_pkg.sv | 29 ++
 rtl/y86_byte_ram.sv | 42 ++++
 rtl/y86_dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, responder FSM states, word width
// and the data-port range check.
package y86_pkg;

    localparam int WORD_W = 64;

    // Pipeline status codes (m_stat / W_stat)
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    // Data-port responder states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // An 8-byte access at a is legal only when a+7 <= mem_bytes-1. Computed in
    // 65 bits so addresses near 2^64 cannot wrap around into the legal range.
    function automatic logic addr_oob(input logic [WORD_W-1:0] a,
                                      input int unsigned       mem_bytes);
        return ({1'b0, a} + 65'd7) >= {33'd0, mem_bytes};
    endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// Single-port byte RAM with an 8-byte little-endian port. Reads are
// combinational from the address; a write commits all 8 bytes in one cycle.
// Byte indices wrap modulo the RAM size; callers range-check beforehand.
module y86_byte_ram #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [7:0]    r_mem [MEM_BYTES];
    logic [AW-1:0] w_idx [8];

    // Per-byte addresses for lanes 0..7 (lane 0 is the least significant byte)
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_idx[i] = i_addr + AW'(i);
        end
    end

    // Little-endian gather of the 8 bytes
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            o_rdata[8*i +: 8] = r_mem[w_idx[i]];
        end
    end

    // Scatter of all 8 store bytes on one edge; contents survive reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[w_idx[i]] <= i_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/y86_dmem_responder.sv
// Memory-stage data-port responder: accepts one 8-byte request at a time,
// waits LATENCY cycles, performs the access against the byte RAM and holds
// the response until the initiator consumes it.
module y86_dmem_responder
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [WORD_W-1:0] i_req_addr,
    input  logic [WORD_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [WORD_W-1:0] o_resp_rdata,
    output logic              o_resp_error,
    output logic              o_busy
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_e       r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_write;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic              r_error;

    logic              w_err;
    logic              w_do_access;
    logic              w_we;
    logic [WORD_W-1:0] w_ram_rdata;

    // The access happens on the last WAIT edge. Reset on that same edge
    // aborts it, so a pending store never reaches the RAM.
    assign w_err       = addr_oob(r_addr, MEM_BYTES);
    assign w_do_access = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_we        = w_do_access && r_write && !w_err && !i_reset;

    y86_byte_ram #(.MEM_BYTES(MEM_BYTES), .AW(AW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (r_addr[AW-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state: accept in IDLE, count down in WAIT, hold RESP until consumed
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_req_valid)   w_next = ST_WAIT;
            ST_WAIT: if (r_cnt == '0)   w_next = ST_RESP;
            ST_RESP: if (i_resp_ready)  w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    // Request latch, latency counter and registered response
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_write <= i_req_write;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_cnt   <= CW'(LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_error <= w_err;
                        r_rdata <= (w_err || r_write) ? '0 : w_ram_rdata;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        r_rdata <= '0;
                        r_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_resp_rdata = r_rdata;
    assign o_resp_error = r_error;

endmodule
